// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake and memory-bus bundle for mem_port_arbiter.
//   Port I  : if_req/if_addr/if_flush in, if_gnt/if_done/if_rdata out (read-only fetch).
//   Port D  : d_req/d_we/d_addr/d_wdata in, d_gnt/d_done/d_rdata out (load/store).
//   Memory  : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in.
// slave  = arbiter side, master = pipeline + memory array side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          if_flush;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (port I) and the data stage (port D). Port D has fixed priority; port I wins
// once STARVE_MAX consecutive D grants have passed it by. One access at a time.
// Ports:
//   clk1          clock, posedge
//   rst           synchronous active-high reset
//   bus           mem_port_arbiter_if.slave (port I, port D, memory bus)
//   perf_if_stall cycles with if_req high and no if_gnt (ARB_PERF_CNT_EN)
//   perf_d_stall  cycles with d_req high and no d_gnt  (ARB_PERF_CNT_EN)
// Optional: define ARB_PERF_CNT_EN to build the stall counters; otherwise 0.
// All outputs are registered; gnt/done/mem_en are computed one cycle ahead.
module mem_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_stall
);
  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] SMAX     = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          sel_d_q, sel_d_d;      // 1: port D owns the current access
  logic          txn_we_q, txn_we_d;    // current access is a store
  logic          kill_q, kill_d;        // port I result flushed
  logic [CW-1:0] starve_q, starve_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_done_q, if_done_d, d_done_q, d_done_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          d_wins;

  // State and registered outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_d_q     <= 1'b0;
      txn_we_q    <= 1'b0;
      kill_q      <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_d_q     <= sel_d_d;
      txn_we_q    <= txn_we_d;
      kill_q      <= kill_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next state, arbitration and next output values
  always_comb begin
    state_d     = state_q;
    sel_d_d     = sel_d_q;
    txn_we_d    = txn_we_q;
    kill_d      = kill_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_wins      = bus.d_req && !(bus.if_req && (starve_q == SMAX));

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (!bus.if_req) starve_d = '0;
        if (d_wins) begin
          state_d     = ISSUE;
          sel_d_d     = 1'b1;
          txn_we_d    = bus.d_we;
          d_gnt_d     = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (bus.if_req && (starve_q != SMAX)) starve_d = starve_q + CW'(1);
        end else if (bus.if_req) begin
          state_d    = ISSUE;
          sel_d_d    = 1'b0;
          txn_we_d   = 1'b0;
          if_gnt_d   = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = bus.if_addr;
          starve_d   = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = LAT_LAST;
        if (!sel_d_q && bus.if_flush) kill_d = 1'b1;
      end
      WAIT: begin
        if (!sel_d_q && bus.if_flush) kill_d = 1'b1;
        if (wait_q == '0) begin
          // mem_rdata is valid now; done/rdata become visible in RESP.
          state_d = RESP;
          if (sel_d_q) begin
            d_done_d = 1'b1;
            if (!txn_we_q) d_rdata_d = bus.mem_rdata;
          end else if (!(kill_q || bus.if_flush)) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      RESP: begin
        // A flush seen here would only set a flag that is cleared on exit.
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_d_q;

  // Saturating stall counters
  always_ff @(posedge clk1) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      if (bus.if_req && !if_gnt_q && (perf_if_q != '1)) perf_if_q <= perf_if_q + 32'd1;
      if (bus.d_req && !d_gnt_q && (perf_d_q != '1))    perf_d_q  <= perf_d_q + 32'd1;
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_d_stall  = perf_d_q;
`else
  assign perf_if_stall = '0;
  assign perf_d_stall  = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, grant-order sequences, reset abort and
// a randomized run against a cycle-count reference model of the arbiter.
module tb_mem_port_arbiter;
  localparam int unsigned AW         = 10;
  localparam int unsigned DW         = 32;
  localparam int unsigned MEM_LAT    = 1;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          NRAND      = 1500;

  logic        clk1;
  logic        rst;
  logic [31:0] perf_if_stall;
  logic [31:0] perf_d_stall;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .bus           (bus),
    .perf_if_stall (perf_if_stall),
    .perf_d_stall  (perf_d_stall)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Memory array: synchronous, read data MEM_LAT cycles after mem_en.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_pipe [MEM_LAT];
  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[0] <= 32'h11110000;
      mem[5] <= 32'hA5A5A5A5;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            pd;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            flush_cyc;   // cycle (0 = IDLE) where if_flush pulses, -1 none
    bit            exp_done;
    logic [DW-1:0] exp_rdata;   // port's rdata at the done cycle
  } vec_t;

  vec_t vecs [10];

  // One access; cycle 0 is IDLE, gnt in 1, done in MEM_LAT+2.
  task automatic do_txn(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk1);
    if (v.pd) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    bus.if_flush = (v.flush_cyc == 0);
    for (int c = 1; c <= int'(MEM_LAT) + 2; c++) begin
      @(negedge clk1);
      if (c == 1) begin
        chk($sformatf("vec%0d_if_gnt", idx), 32'(bus.if_gnt), 32'(!v.pd));
        chk($sformatf("vec%0d_d_gnt", idx), 32'(bus.d_gnt), 32'(v.pd));
        chk($sformatf("vec%0d_mem_en", idx), 32'(bus.mem_en), 32'd1);
        chk($sformatf("vec%0d_mem_we", idx), 32'(bus.mem_we), 32'(v.pd && v.we));
        chk($sformatf("vec%0d_mem_addr", idx), 32'(bus.mem_addr), 32'(v.addr));
        if (v.pd && v.we) chk($sformatf("vec%0d_mem_wdata", idx), bus.mem_wdata, v.wdata);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
      end
      if (c == int'(MEM_LAT) + 1) begin
        chk($sformatf("vec%0d_mem_en_off", idx), 32'(bus.mem_en), 32'd0);
        chk($sformatf("vec%0d_early_done", idx), 32'(bus.if_done | bus.d_done), 32'd0);
      end
      if (c == int'(MEM_LAT) + 2) begin
        if (v.pd) begin
          chk($sformatf("vec%0d_d_done", idx), 32'(bus.d_done), 32'(v.exp_done));
          chk($sformatf("vec%0d_d_rdata", idx), bus.d_rdata, v.exp_rdata);
        end else begin
          chk($sformatf("vec%0d_if_done", idx), 32'(bus.if_done), 32'(v.exp_done));
          chk($sformatf("vec%0d_if_rdata", idx), bus.if_rdata, v.exp_rdata);
        end
      end
      bus.if_flush = (c == v.flush_cyc);
    end
    bus.if_flush = 1'b0;
  endtask

  // Record grant order (1 = D, 0 = I) with both ports requesting.
  bit glog [8];
  task automatic grant_seq(input int n, input bit reraise);
    int got;
    int guard;
    bit fin;
    got = 0; guard = 0; fin = 0;
    for (int i = 0; i < 8; i++) glog[i] = 1'b0;
    @(negedge clk1);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk1);
    bus.if_req = 1'b1; bus.if_addr = 10'd7;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd8;
    while (!fin && guard < 200) begin
      @(negedge clk1);
      guard++;
      if (bus.d_gnt && got < 8) begin glog[got] = 1'b1; got++; bus.d_req = 1'b0; end
      if (bus.if_gnt && got < 8) begin glog[got] = 1'b0; got++; bus.if_req = 1'b0; end
      if (got >= n && (bus.d_done || bus.if_done)) fin = 1'b1;
      else if (bus.d_done && reraise) bus.d_req = 1'b1;
    end
    chk("grant_seq_timeout", 32'(fin), 32'd1);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  bit exp_simul [2]  = '{1'b1, 1'b0};
  bit exp_starve [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Random-phase reference model state
  logic [DW-1:0] ref_mem [1024];
  int            cyc, free_at, streak, t_start;
  bit            t_valid, t_pd, t_we, t_killed, d_busy, i_busy;
  bit            e_ig, e_dg, e_id, e_dd, e_men, at_done;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data, e_if_rdata, e_d_rdata;
  logic [31:0]   e_perf_if, e_perf_d;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    vecs[0] = '{pd:0, we:0, addr:10'd5,    wdata:32'h0,        flush_cyc:-1, exp_done:1, exp_rdata:32'hA5A5A5A5};
    vecs[1] = '{pd:1, we:1, addr:10'd20,   wdata:32'h12345678, flush_cyc:-1, exp_done:1, exp_rdata:32'h0};
    vecs[2] = '{pd:1, we:0, addr:10'd20,   wdata:32'h0,        flush_cyc:-1, exp_done:1, exp_rdata:32'h12345678};
    vecs[3] = '{pd:0, we:0, addr:10'd20,   wdata:32'h0,        flush_cyc:0,  exp_done:1, exp_rdata:32'h12345678};
    vecs[4] = '{pd:0, we:0, addr:10'd5,    wdata:32'h0,        flush_cyc:2,  exp_done:0, exp_rdata:32'h12345678};
    vecs[5] = '{pd:1, we:1, addr:10'd1023, wdata:32'hDEADBEEF, flush_cyc:2,  exp_done:1, exp_rdata:32'h12345678};
    vecs[6] = '{pd:1, we:0, addr:10'd1023, wdata:32'h0,        flush_cyc:1,  exp_done:1, exp_rdata:32'hDEADBEEF};
    vecs[7] = '{pd:0, we:0, addr:10'd1023, wdata:32'h0,        flush_cyc:1,  exp_done:0, exp_rdata:32'h12345678};
    vecs[8] = '{pd:0, we:0, addr:10'd0,    wdata:32'h0,        flush_cyc:-1, exp_done:1, exp_rdata:32'h11110000};
    vecs[9] = '{pd:1, we:0, addr:10'd0,    wdata:32'h0,        flush_cyc:-1, exp_done:1, exp_rdata:32'h11110000};

    repeat (3) @(negedge clk1);
    rst = 1'b0;
    chk("rst_gnt",   32'({bus.if_gnt, bus.d_gnt}), 32'd0);
    chk("rst_done",  32'({bus.if_done, bus.d_done}), 32'd0);
    chk("rst_mem",   32'({bus.mem_en, bus.mem_we}), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata | bus.mem_wdata, 32'd0);

    for (int i = 0; i < 10; i++) do_txn(i);

    grant_seq(2, 1'b0);
    for (int i = 0; i < 2; i++) chk($sformatf("simul_grant%0d", i), 32'(glog[i]), 32'(exp_simul[i]));
    grant_seq(6, 1'b1);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), 32'(exp_starve[i] == glog[i]), 32'd1);

    // Reset during WAIT of a load abandons it.
    @(negedge clk1);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd20;
    @(negedge clk1);
    chk("abort_d_gnt", 32'(bus.d_gnt), 32'd1);
    bus.d_req = 1'b0;
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    chk("abort_ctl", 32'({bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.mem_en, bus.mem_we}), 32'd0);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort_data", bus.if_rdata | bus.d_rdata | bus.mem_wdata, 32'd0);
    chk("abort_perf", perf_if_stall | perf_d_stall, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      chk($sformatf("abort_no_done%0d", i), 32'({bus.d_done, bus.if_done}), 32'd0);
    end

    // Randomized traffic against the cycle-count model.
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    free_at = 0; streak = 0; t_valid = 0; t_start = 0; t_pd = 0; t_we = 0; t_killed = 0;
    t_addr = '0; t_data = '0; d_busy = 0; i_busy = 0;
    e_if_rdata = '0; e_d_rdata = '0; e_perf_if = '0; e_perf_d = '0;
    for (cyc = 0; cyc < NRAND; cyc++) begin
      @(negedge clk1);
      e_ig    = t_valid && !t_pd && cyc == t_start + 1;
      e_dg    = t_valid && t_pd && cyc == t_start + 1;
      e_men   = t_valid && cyc == t_start + 1;
      at_done = t_valid && cyc == t_start + int'(MEM_LAT) + 2;
      e_dd    = at_done && t_pd;
      e_id    = at_done && !t_pd && !t_killed;
      if (e_dd && !t_we) e_d_rdata = t_data;
      if (e_id) e_if_rdata = t_data;
      chk($sformatf("rnd%0d_if_gnt", cyc), 32'(bus.if_gnt), 32'(e_ig));
      chk($sformatf("rnd%0d_d_gnt", cyc), 32'(bus.d_gnt), 32'(e_dg));
      chk($sformatf("rnd%0d_if_done", cyc), 32'(bus.if_done), 32'(e_id));
      chk($sformatf("rnd%0d_d_done", cyc), 32'(bus.d_done), 32'(e_dd));
      chk($sformatf("rnd%0d_if_rdata", cyc), bus.if_rdata, e_if_rdata);
      chk($sformatf("rnd%0d_d_rdata", cyc), bus.d_rdata, e_d_rdata);
      chk($sformatf("rnd%0d_mem_en", cyc), 32'({bus.mem_en, bus.mem_we}), 32'({e_men, e_men && t_pd && t_we}));
      if (e_men) chk($sformatf("rnd%0d_mem_addr", cyc), 32'(bus.mem_addr), 32'(t_addr));
`ifdef ARB_PERF_CNT_EN
      chk($sformatf("rnd%0d_perf", cyc), perf_if_stall ^ perf_d_stall, e_perf_if ^ e_perf_d);
      chk($sformatf("rnd%0d_perf_if", cyc), perf_if_stall, e_perf_if);
`else
      chk($sformatf("rnd%0d_perf", cyc), perf_if_stall | perf_d_stall, 32'd0);
`endif
      if (e_dg) bus.d_req = 1'b0;
      if (e_ig) bus.if_req = 1'b0;
      if (at_done) begin
        if (t_pd) d_busy = 0; else i_busy = 0;
        t_valid = 0;
      end
      if (cyc > 0) begin
        if (!bus.d_req && !d_busy && $urandom_range(0, 2) == 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_addr  = ($urandom_range(0, 9) == 0) ? 10'd1023 : AW'($urandom_range(0, 15));
          bus.d_wdata = $urandom;
        end
        if (!bus.if_req && !i_busy && $urandom_range(0, 2) == 0) begin
          bus.if_req  = 1'b1;
          bus.if_addr = AW'($urandom_range(0, 15));
        end
        bus.if_flush = ($urandom_range(0, 4) == 0) && !at_done;
      end
      if (t_valid && !t_pd && bus.if_flush && cyc >= t_start + 1 && cyc <= t_start + int'(MEM_LAT) + 1)
        t_killed = 1;
      if (bus.if_req && !e_ig) e_perf_if = e_perf_if + 32'd1;
      if (bus.d_req && !e_dg)  e_perf_d  = e_perf_d + 32'd1;
      if (cyc >= free_at) begin
        if (!bus.if_req) streak = 0;
        if (bus.d_req && !(bus.if_req && streak == int'(STARVE_MAX))) begin
          t_valid = 1; t_pd = 1; t_we = bus.d_we; t_addr = bus.d_addr; t_killed = 0;
          t_start = cyc; free_at = cyc + int'(MEM_LAT) + 3; d_busy = 1;
          if (bus.d_we) begin ref_mem[bus.d_addr] = bus.d_wdata; t_data = bus.d_wdata; end
          else t_data = ref_mem[bus.d_addr];
          if (bus.if_req && streak < int'(STARVE_MAX)) streak++;
        end else if (bus.if_req) begin
          t_valid = 1; t_pd = 0; t_we = 0; t_addr = bus.if_addr; t_killed = 0;
          t_start = cyc; free_at = cyc + int'(MEM_LAT) + 3; i_busy = 1;
          t_data = ref_mem[bus.if_addr];
          streak = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 1K x 32 unified instruction/data memory between two requesters: instruction fetch (port I, read-only) and the data memory stage (port D, LW/SW).
- Fixed priority to port D, with a starvation guard for port I.
- One outstanding transaction at a time; request/grant/done handshake per port.
- Sits between the pipeline stages and the memory array.

Parameters:
- AW, 10, word address width (1024 words).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, legal range 1..15.
- STARVE_MAX, 4, consecutive port-D grants allowed while port I waits; legal range 1..15.

Ports:
- clk1  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  port I request; held until if_gnt.
- if_addr  in  AW  port I word address; stable while if_req high.
- if_gnt  out  1  one-cycle grant pulse to port I.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DW  fetched instruction word.
- if_flush  in  1  kills the outstanding port I fetch result (taken branch).
- d_req  in  1  port D request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  port D word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle grant pulse to port D.
- d_done  out  1  one-cycle completion pulse (both loads and stores).
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only ever high together with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  valid MEM_LAT cycles after the mem_en cycle.
- perf_if_stall  out  32  performance counter (see Optional Feature).
- perf_d_stall  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, starvation counter 0, kill flag 0.
- Reset mid-transaction abandons the access. No done pulse is issued, and mem_rdata arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is high in cycle T, latch the winner's addr/we/wdata and go to ISSUE.
- ISSUE (cycle T+1):
  - mem_en = 1.
  - mem_we = d_we for port D; mem_we = 0 for port I.
  - mem_addr and mem_wdata are registered.
  - The winner's gnt pulses in this cycle.
- WAIT: runs for MEM_LAT cycles. mem_rdata is captured on the final WAIT cycle (T+1+MEM_LAT), then the FSM goes to RESP.
- RESP (cycle T+2+MEM_LAT):
  - The winner's done pulses; rdata is updated for reads only.
  - For stores, d_rdata holds its previous value.
  - Next state is IDLE.
- Latency:
  - req to gnt: 1 cycle.
  - req to done: MEM_LAT+2 cycles.
  - Back-to-back throughput: one access per MEM_LAT+3 cycles, because IDLE samples req in the cycle after RESP.
- Requester rules:
  - The requester deasserts req on the cycle after seeing gnt.
  - req is ignored outside IDLE.
  - req still high in IDLE is treated as a new request.
- Arbitration, when both requests are high in IDLE:
  - Port D wins unless starve_cnt == STARVE_MAX, in which case port I wins.
- starve_cnt (4-bit):
  - Increments on each D grant while if_req is high.
  - Clears on an I grant, or in any IDLE cycle where if_req is low.
  - Saturates at STARVE_MAX.
- Flush:
  - if_flush high in any cycle from ISSUE through RESP of a port I transaction sets the kill flag.
  - In RESP with the kill flag set, if_done stays 0 and if_rdata is unchanged.
  - The kill flag clears on leaving RESP.
  - if_flush in IDLE has no effect.
  - if_flush during a port D transaction has no effect.
- Addresses are word addresses, with no wrap logic; the address is passed through unmodified.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - perf_if_stall counts cycles with if_req high and no if_gnt.
  - perf_d_stall counts cycles with d_req high and no d_gnt.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, and clear on rst.
- When not defined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- MEM_LAT=1, memory preloaded Mem[5]=32'hA5A5A5A5; if_req with if_addr=5 in cycle 0 -> if_gnt and mem_en in cycle 1, if_done with if_rdata=32'hA5A5A5A5 in cycle 3.
- d_req, d_we=1, d_addr=20, d_wdata=32'h12345678 -> mem_we=1 and mem_addr=20 in the gnt cycle, d_done 2 cycles later; a following load from address 20 returns 32'h12345678.
- if_req and d_req both asserted in the same cycle -> port D is granted first, port I on the next arbitration.
- STARVE_MAX=4, if_req held high, d_req re-raised after every done -> 4 D grants, then an I grant, then D resumes.
- Port I fetch in flight, if_flush pulsed in the WAIT cycle -> no if_done, if_rdata unchanged, FSM back in IDLE on schedule.
- rst asserted during WAIT of a port D load -> all outputs 0 in the next cycle, no d_done; with ARB_PERF_CNT_EN, counters read 0.
